// File: rtl/id_inst_sequencer_pkg.sv
// Shared types and constants for the ID instruction sequencer.
package id_inst_sequencer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned COUNT_W = 3;
  localparam int unsigned DROP_W  = 2;

  localparam logic [XLEN-1:0] INST_BUBBLE = 32'h0000_0000;

  typedef enum logic {
    ISEQ_RUN  = 1'b0,
    ISEQ_DROP = 1'b1
  } iseq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } iseq_entry_t;

endpackage

// File: rtl/id_inst_sequencer_fifo.sv
// Small circular queue of {pc,inst} entries with clear; head is a mux of registered storage.
module id_inst_sequencer_fifo
  import id_inst_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  iseq_entry_t        wdata_i,
  output iseq_entry_t        head_c,
  output logic [COUNT_W-1:0] count_o,
  output logic               drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(DEPTH);

  iseq_entry_t        mem_q [DEPTH];
  iseq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               full_c;
  logic               pop_en_c;
  logic               wr_en_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign full_c   = (count_q == CNT_FULL);
  assign pop_en_c = pop_i & (count_q != '0);
  assign wr_en_c  = push_i & (~full_c | pop_en_c);
  assign drop_c   = push_i & full_c & ~pop_en_c;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_en_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + COUNT_W'(wr_en_c) - COUNT_W'(pop_en_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/id_inst_sequencer.sv
// Delivers queued Icache responses to ID one per cycle; holds on stall/load-use and
// discards wrong-path responses for a fixed window after a flush.
module id_inst_sequencer
  import id_inst_sequencer_pkg::*;
#(
  parameter int unsigned      DEPTH      = 2,
  parameter int unsigned      FLUSH_DROP = 1,
  parameter logic [XLEN-1:0]  BUBBLE     = INST_BUBBLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Icache_ready_i,
  input  logic [XLEN-1:0]    Icache_inst_i,
  input  logic [XLEN-1:0]    Icache_pc_i,
  input  logic               fc_stall_id_i,
  input  logic               fc_flush_id_i,
  input  logic               id_load_use_flag_i,
  output logic               iseq_fetch_stall_o,
  output logic               iseq_valid_o,
  output logic [XLEN-1:0]    iseq_inst_o,
  output logic [XLEN-1:0]    iseq_pc_o,
  output logic [COUNT_W-1:0] iseq_count_o,
  output logic               iseq_ovf_o
);

  localparam logic [DROP_W-1:0]  DROP_LOAD  = DROP_W'(FLUSH_DROP);
  localparam logic [COUNT_W-1:0] CNT_STALL  = COUNT_W'(DEPTH - 1);

  iseq_state_e        state_q, state_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;
  logic               clear_c;
  logic               push_c;
  logic               pop_c;
  logic               valid_c;
  logic               fifo_drop_c;
  logic [COUNT_W-1:0] count_c;
  iseq_entry_t        head_c;
  iseq_entry_t        wdata_c;

  assign valid_c = (count_c != '0);
  assign pop_c   = valid_c & ~fc_stall_id_i & ~id_load_use_flag_i & ~fc_flush_id_i;
  assign push_c  = Icache_ready_i & (state_q == ISEQ_RUN) & ~fc_flush_id_i;
  assign wdata_c = '{pc: Icache_pc_i, inst: Icache_inst_i};

  id_inst_sequencer_fifo #(
    .DEPTH (DEPTH)
  ) u_iseq_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wdata_c),
    .head_c  (head_c),
    .count_o (count_c),
    .drop_c  (fifo_drop_c)
  );

  // Flush always clears the queue and (re)opens the wrong-path drop window.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    clear_c    = 1'b0;
    ovf_d      = ovf_q | fifo_drop_c;
    case (state_q)
      ISEQ_RUN: begin
        if (fc_flush_id_i) begin
          clear_c = 1'b1;
          if (FLUSH_DROP != 0) begin
            state_d    = ISEQ_DROP;
            drop_cnt_d = DROP_LOAD;
          end
        end
      end
      ISEQ_DROP: begin
        if (fc_flush_id_i) begin
          clear_c    = 1'b1;
          drop_cnt_d = DROP_LOAD;
          if (FLUSH_DROP == 0) begin
            state_d = ISEQ_RUN;
          end
        end else if (Icache_ready_i) begin
          drop_cnt_d = drop_cnt_q - DROP_W'(1);
          if (drop_cnt_q <= DROP_W'(1)) begin
            state_d = ISEQ_RUN;
          end
        end
      end
      default: state_d = ISEQ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ISEQ_RUN;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign iseq_valid_o       = valid_c;
  assign iseq_inst_o        = valid_c ? head_c.inst : BUBBLE;
  assign iseq_pc_o          = valid_c ? head_c.pc : '0;
  assign iseq_count_o       = count_c;
  assign iseq_fetch_stall_o = (count_c >= CNT_STALL) | (state_q == ISEQ_DROP);
  assign iseq_ovf_o         = ovf_q;

endmodule

// File: tb/tb_id_inst_sequencer.sv
// Table-driven and scoreboard bench for id_inst_sequencer (DEPTH=2, FLUSH_DROP=1).
module tb_id_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        lu;
  logic        fetch_stall;
  logic        valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [2:0]  count;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_inst_sequencer #(
    .DEPTH      (2),
    .FLUSH_DROP (1),
    .BUBBLE     (32'h0)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Icache_ready_i     (ready),
    .Icache_inst_i      (inst_in),
    .Icache_pc_i        (pc_in),
    .fc_stall_id_i      (stall),
    .fc_flush_id_i      (flush),
    .id_load_use_flag_i (lu),
    .iseq_fetch_stall_o (fetch_stall),
    .iseq_valid_o       (valid),
    .iseq_inst_o        (inst_out),
    .iseq_pc_o          (pc_out),
    .iseq_count_o       (count),
    .iseq_ovf_o         (ovf)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        lu;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_fs;
    logic        e_ovf;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [31:0] i, input logic [31:0] p,
                              input logic s, input logic f, input logic l,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                              input logic [2:0] ec, input logic efs, input logic eo);
    vec_t v;
    v.rdy = r; v.inst = i; v.pc = p; v.stall = s; v.flush = f; v.lu = l;
    v.e_valid = ev; v.e_inst = ei; v.e_pc = ep; v.e_cnt = ec; v.e_fs = efs; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [2:0] ec,
                         input logic efs, input logic eo);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".inst"}, inst_out, ei);
    chk({tag, ".pc"}, pc_out, ep);
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".fstall"}, 32'(fetch_stall), 32'(efs));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] p,
                       input logic s, input logic f, input logic l);
    ready = r; inst_in = i; pc_in = p; stall = s; flush = f; lu = l;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] IA = 32'hA000_0001, IB = 32'hB000_0002, IC = 32'hC000_0003;
  localparam logic [31:0] IX = 32'hDEAD_0001, IY = 32'hDEAD_0002, IZ = 32'h2000_0003;
  localparam logic [31:0] ID = 32'hD000_0004, IE = 32'hE000_0005;

  logic [63:0] sbq [$];

  initial begin
    // stream
    vecs[0]  = mk(1, IA, 32'h00, 0,0,0, 1, IA, 32'h00, 1, 1, 0);
    vecs[1]  = mk(1, IB, 32'h04, 0,0,0, 1, IB, 32'h04, 1, 1, 0);
    vecs[2]  = mk(1, IC, 32'h08, 0,0,0, 1, IC, 32'h08, 1, 1, 0);
    vecs[3]  = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 0);
    // stall holds head while next response queues
    vecs[4]  = mk(1, IA, 32'h10, 0,0,0, 1, IA, 32'h10, 1, 1, 0);
    vecs[5]  = mk(1, IB, 32'h14, 1,0,0, 1, IA, 32'h10, 2, 1, 0);
    vecs[6]  = mk(0, 0,  0,      1,0,0, 1, IA, 32'h10, 2, 1, 0);
    vecs[7]  = mk(0, 0,  0,      0,0,0, 1, IB, 32'h14, 1, 1, 0);
    vecs[8]  = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 0);
    // load-use re-presents head
    vecs[9]  = mk(1, IA, 32'h20, 0,0,0, 1, IA, 32'h20, 1, 1, 0);
    vecs[10] = mk(1, IB, 32'h24, 0,0,1, 1, IA, 32'h20, 2, 1, 0);
    vecs[11] = mk(0, 0,  0,      0,0,0, 1, IB, 32'h24, 1, 1, 0);
    vecs[12] = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 0);
    // flush with ready, one wrong-path drop, then Z
    vecs[13] = mk(1, IA, 32'h30, 0,0,0, 1, IA, 32'h30, 1, 1, 0);
    vecs[14] = mk(1, IB, 32'h34, 1,0,0, 1, IA, 32'h30, 2, 1, 0);
    vecs[15] = mk(1, IX, 32'h38, 0,1,0, 0, 0,  0,      0, 1, 0);
    vecs[16] = mk(1, IY, 32'h3c, 0,0,0, 0, 0,  0,      0, 0, 0);
    vecs[17] = mk(1, IZ, 32'h100,0,0,0, 1, IZ, 32'h100,1, 1, 0);
    vecs[18] = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 0);
    // flush during stall, then flush during DROP restarts the window
    vecs[19] = mk(1, IA, 32'h40, 0,0,0, 1, IA, 32'h40, 1, 1, 0);
    vecs[20] = mk(1, IB, 32'h44, 1,1,0, 0, 0,  0,      0, 1, 0);
    vecs[21] = mk(1, IC, 32'h48, 0,1,0, 0, 0,  0,      0, 1, 0);
    vecs[22] = mk(1, ID, 32'h4c, 0,0,0, 0, 0,  0,      0, 0, 0);
    vecs[23] = mk(1, IE, 32'h50, 0,0,0, 1, IE, 32'h50, 1, 1, 0);
    vecs[24] = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 0);
    // overflow while full and stalled, sticky
    vecs[25] = mk(1, IA, 32'h60, 1,0,0, 1, IA, 32'h60, 1, 1, 0);
    vecs[26] = mk(1, IB, 32'h64, 1,0,0, 1, IA, 32'h60, 2, 1, 0);
    vecs[27] = mk(1, IC, 32'h68, 1,0,0, 1, IA, 32'h60, 2, 1, 1);
    vecs[28] = mk(0, 0,  0,      0,0,0, 1, IB, 32'h64, 1, 1, 1);
    vecs[29] = mk(0, 0,  0,      0,0,0, 0, 0,  0,      0, 0, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 32'h0, 32'h0, 3'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk_all("idle", 0, 32'h0, 32'h0, 3'd0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rdy, vecs[i].inst, vecs[i].pc, vecs[i].stall, vecs[i].flush, vecs[i].lu);
      cycle();
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc,
              vecs[i].e_cnt, vecs[i].e_fs, vecs[i].e_ovf);
    end

    // async reset mid-cycle clears everything including sticky ovf
    drive(1, IA, 32'h80, 1, 0, 0);
    cycle();
    drive(1, IB, 32'h84, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 32'h0, 32'h0, 3'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk_all("post_rst", 0, 32'h0, 32'h0, 3'd0, 0, 0);

    // random stream against a queue scoreboard (no flush, no overflow)
    for (int c = 0; c < 400; c++) begin
      logic s, l, r, pm;
      logic [31:0] ri, rp;
      chk("sb.valid", 32'(valid), 32'(sbq.size() != 0));
      chk("sb.count", 32'(count), 32'(sbq.size()));
      chk("sb.fstall", 32'(fetch_stall), 32'(sbq.size() >= 1));
      chk("sb.ovf", 32'(ovf), 32'h0);
      if (sbq.size() != 0) begin
        chk("sb.inst", inst_out, sbq[0][31:0]);
        chk("sb.pc", pc_out, sbq[0][63:32]);
      end
      s  = ($urandom_range(3) == 0);
      l  = ($urandom_range(4) == 0);
      pm = (sbq.size() != 0) && !s && !l;
      r  = ($urandom_range(1) == 1) && ((sbq.size() < 2) || pm);
      ri = $urandom;
      rp = 32'(c) << 2;
      drive(r, ri, rp, s, 0, l);
      if (pm) void'(sbq.pop_front());
      if (r) sbq.push_back({rp, ri});
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
